// File: rtl/riskow_pkg.sv
// Shared ALU operation codes, RV32I opcode/funct7 constants and the decoded-entry
// record used by the ALU issue stage and its decoder.
package riskow_pkg;

  // Codes 0xA-0xC are reserved for ALU functions this stage never issues.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_OR  = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_LTU = 4'h5;
  localparam logic [3:0] ALU_LTS = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;
  localparam logic [3:0] ALU_SRA = 4'h8;
  localparam logic [3:0] ALU_SLL = 4'h9;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    dec_t        dec;
    logic [31:0] pc;
  } entry_t;

  function automatic logic signed [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decoder producing the ALU operation,
// operands, destination and legality of one instruction.
module alu_op_decoder
  import riskow_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output dec_t        dec_o
);

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic signed [31:0] imm_i_s;
  logic [31:0]        imm_u;
  logic [31:0]        shamt;
  logic [3:0]         op;
  logic [31:0]        x;
  logic [31:0]        y;
  logic               legal;

  assign opcode  = instr_i[6:0];
  assign f3      = instr_i[14:12];
  assign f7      = instr_i[31:25];
  assign imm_i_s = sext12(instr_i[31:20]);
  assign imm_u   = {instr_i[31:12], 12'b0};
  assign shamt   = {27'b0, instr_i[24:20]};

  always_comb begin
    op    = ALU_ADD;
    x     = rs1_i;
    y     = 32'($unsigned(imm_i_s));
    legal = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        legal = 1'b1;
        case (f3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_LTS;
          3'b011: op = ALU_LTU;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          3'b001: begin
            op    = ALU_SLL;
            y     = shamt;
            legal = (f7 == F7_BASE);
          end
          default: begin
            op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            y     = shamt;
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        y     = rs2_i;
        legal = (f7 == F7_BASE);
        case (f3)
          3'b000: begin
            op    = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          3'b001: op = ALU_SLL;
          3'b010: op = ALU_LTS;
          3'b011: op = ALU_LTU;
          3'b100: op = ALU_XOR;
          3'b101: begin
            op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          3'b110: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        x     = '0;
        y     = imm_u;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        x     = pc_i;
        y     = imm_u;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries still flow downstream, but as a harmless ADD 0,0 with no writeback.
  assign dec_o.op      = legal ? op : ALU_ADD;
  assign dec_o.x       = legal ? x : '0;
  assign dec_o.y       = legal ? y : '0;
  assign dec_o.rd      = instr_i[11:7];
  assign dec_o.rd_we   = legal && (instr_i[11:7] != 5'd0);
  assign dec_o.illegal = !legal;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: decodes one instruction per handshake and
// holds it in an output register backed by a one-entry skid register.
module alu_issue_stage
  import riskow_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit SKID_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_value,
  input  logic [XLEN-1:0] in_rs2_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_operation,
  output logic [XLEN-1:0] out_x,
  output logic [XLEN-1:0] out_y,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  dec_t       dec;
  entry_t     in_entry;
  logic [1:0] state_q, state_d;
  entry_t     out_q, out_d;
  entry_t     skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  logic       accept, consume;

  alu_op_decoder u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .rs1_i   (in_rs1_value),
    .rs2_i   (in_rs2_value),
    .dec_o   (dec)
  );

  assign in_entry  = '{dec: dec, pc: in_pc};
  assign out_valid = (state_q != ST_EMPTY);
  // Without the skid the FULL state is unreachable: in ONE an accept implies a consume.
  assign in_ready  = SKID_ENABLE ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            out_d   = in_entry;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_d = in_entry;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_entry;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d = ST_ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign out_operation = out_q.dec.op;
  assign out_x         = out_q.dec.x;
  assign out_y         = out_q.dec.y;
  assign out_rd        = out_q.dec.rd;
  assign out_rd_we     = out_q.dec.rd_we;
  assign out_pc        = out_q.pc;
  assign out_illegal   = out_q.dec.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus backpressure,
// flush and asynchronous reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_operation;
  logic [31:0] out_x, out_y, out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_illegal;

  int errors = 0;
  int checks = 0;
  logic [4:0] got[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .SKID_ENABLE(1'b1)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_value  (in_rs1),
    .in_rs2_value  (in_rs2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_operation (out_operation),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_rd        (out_rd),
    .out_rd_we     (out_rd_we),
    .out_pc        (out_pc),
    .out_illegal   (out_illegal)
  );

  // Records every consumed entry's rd, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_rd);
  end

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  op;
    logic [31:0] x, y;
    logic [4:0]  rd;
    logic        we, ill;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_add(input logic [4:0] rd);
    logic [31:0] base;
    base = 32'h0031_0033;
    return base | {20'b0, rd, 7'b0};
  endfunction

  initial begin
    vecs[0]  = '{32'hFFF08293, 32'h0,   32'd10,        32'h0, 4'd0, 32'd10,        32'hFFFFFFFF, 5'd5,  1'b1, 1'b0};
    vecs[1]  = '{32'h40415193, 32'h4,   32'h80000000,  32'h0, 4'd8, 32'h80000000,  32'd4,        5'd3,  1'b1, 1'b0};
    vecs[2]  = '{32'h42415193, 32'h8,   32'h80000000,  32'h0, 4'd0, 32'h0,         32'h0,        5'd3,  1'b0, 1'b1};
    vecs[3]  = '{32'h12345397, 32'h100, 32'hDEAD,      32'h0, 4'd0, 32'h100,       32'h12345000, 5'd7,  1'b1, 1'b0};
    vecs[4]  = '{32'h00001037, 32'h104, 32'h1234,      32'h0, 4'd0, 32'h0,         32'h1000,     5'd0,  1'b0, 1'b0};
    vecs[5]  = '{32'h40C58533, 32'h108, 32'd5,         32'd7, 4'd1, 32'd5,         32'd7,        5'd10, 1'b1, 1'b0};
    vecs[6]  = '{32'h003100B3, 32'h10C, 32'hA,         32'hB, 4'd0, 32'hA,         32'hB,        5'd1,  1'b1, 1'b0};
    vecs[7]  = '{32'h0062B233, 32'h110, 32'd1,         32'd2, 4'd5, 32'd1,         32'd2,        5'd4,  1'b1, 1'b0};
    vecs[8]  = '{32'h40A4D433, 32'h114, 32'hF0000000,  32'd4, 4'd8, 32'hF0000000,  32'd4,        5'd8,  1'b1, 1'b0};
    vecs[9]  = '{32'h01F09093, 32'h118, 32'd3,         32'h9, 4'd9, 32'd3,         32'd31,       5'd1,  1'b1, 1'b0};
    vecs[10] = '{32'h7FF1F113, 32'h11C, 32'hFFFF,      32'h0, 4'd4, 32'hFFFF,      32'h7FF,      5'd2,  1'b1, 1'b0};
    vecs[11] = '{32'h80006113, 32'h120, 32'h55,        32'h0, 4'd2, 32'h55,        32'hFFFFF800, 5'd2,  1'b1, 1'b0};
    vecs[12] = '{32'h00512093, 32'h124, 32'd9,         32'h0, 4'd6, 32'd9,         32'd5,        5'd1,  1'b1, 1'b0};
    vecs[13] = '{32'h000000EF, 32'h128, 32'h77,        32'h1, 4'd0, 32'h0,         32'h0,        5'd1,  1'b0, 1'b1};
    vecs[14] = '{32'h022081B3, 32'h12C, 32'h3,         32'h4, 4'd0, 32'h0,         32'h0,        5'd3,  1'b0, 1'b1};
    vecs[15] = '{32'h40109093, 32'h130, 32'h5,         32'h0, 4'd0, 32'h0,         32'h0,        5'd1,  1'b0, 1'b1};
    vecs[16] = '{32'h003140B3, 32'h134, 32'd6,         32'd3, 4'd3, 32'd6,         32'd3,        5'd1,  1'b1, 1'b0};
    vecs[17] = '{32'h00315093, 32'h138, 32'h80,        32'h0, 4'd7, 32'h80,        32'd3,        5'd1,  1'b1, 1'b0};
    vecs[18] = '{32'h003110B3, 32'h13C, 32'd1,         32'd4, 4'd9, 32'd1,         32'd4,        5'd1,  1'b1, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_x", out_x, 32'd0);
    chk("reset out_rd", {27'b0, out_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Decode table, streaming with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
      step();
      chk($sformatf("vec%0d valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d op", i), {28'b0, out_operation}, {28'b0, vecs[i].op});
      chk($sformatf("vec%0d x", i), out_x, vecs[i].x);
      chk($sformatf("vec%0d y", i), out_y, vecs[i].y);
      chk($sformatf("vec%0d rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
      chk($sformatf("vec%0d rd_we", i), {31'b0, out_rd_we}, {31'b0, vecs[i].we});
      chk($sformatf("vec%0d illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      chk($sformatf("vec%0d pc", i), out_pc, vecs[i].pc);
    end
    in_valid = 1'b0;
    step();
    chk("drain out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: three back-to-back words with the consumer stalled.
    got.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_rs1 = 32'h1; in_rs2 = 32'h2; in_pc = 32'h400;
    in_instr = mk_add(5'd1);
    step();
    chk("bp1 out_rd", {27'b0, out_rd}, 32'd1);
    chk("bp1 in_ready", {31'b0, in_ready}, 32'd1);
    in_instr = mk_add(5'd2);
    step();
    chk("bp2 out_rd held", {27'b0, out_rd}, 32'd1);
    chk("bp2 in_ready", {31'b0, in_ready}, 32'd0);
    in_instr = mk_add(5'd3);
    step();
    chk("bp3 out_rd held", {27'b0, out_rd}, 32'd1);
    chk("bp3 in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp rel out_rd", {27'b0, out_rd}, 32'd2);
    chk("bp rel in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp third out_rd", {27'b0, out_rd}, 32'd3);
    step();
    chk("bp end out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp consumed count", got.size(), 32'd3);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp order %0d", i), {27'b0, got[i]}, i + 1);

    // Flush while FULL, with a word offered the same cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk_add(5'd4);
    step();
    in_instr = mk_add(5'd5);
    step();
    chk("fl full in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1; in_instr = mk_add(5'd6);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl in_ready", {31'b0, in_ready}, 32'd1);
    got.delete();
    out_ready = 1'b1;
    step();
    step();
    chk("fl nothing consumed", got.size(), 32'd0);
    chk("fl out_valid later", {31'b0, out_valid}, 32'd0);

    // Flush beats an accept while ONE.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk_add(5'd7);
    step();
    chk("fl1 out_valid", {31'b0, out_valid}, 32'd1);
    flush = 1'b1; in_instr = mk_add(5'd8);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1 after out_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("fl1 dropped stays out", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of FULL.
    out_ready = 1'b0; in_valid = 1'b1; in_rs1 = 32'h11; in_pc = 32'h200;
    in_instr = mk_add(5'd9);
    step();
    in_instr = mk_add(5'd10);
    step();
    in_valid = 1'b0;
    chk("rst pre in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst pre out_x", out_x, 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst async in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst async out_x", out_x, 32'd0);
    chk("rst async out_y", out_y, 32'd0);
    chk("rst async out_pc", out_pc, 32'd0);
    chk("rst async out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst async out_rd_we", {31'b0, out_rd_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst post out_valid", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
